ifu_inst_queue: RTL

Instruction queue sitting directly upstream of the decode stage, replacing a plain fetch/decode pipeline register. It buffers up to DEPTH fetched instructions, each with its address and branch-prediction tag, and accepts them from fetch through a valid/ready handshake. It presents one registered instruction per cycle to decode, honouring pipeline stall and flush from the control unit. An empty queue presents a NOP bubble.

---
 rtl/ifu_inst_queue_pkg.sv | 17 +
 rtl/ifu_queue_mem.sv | 25 ++
 rtl/ifu_inst_queue.sv | 93 +++++++++
 3 files changed

// File: rtl/ifu_inst_queue_pkg.sv
// Shared core definitions for the instruction fetch queue: widths, the NOP bubble
// and the packed entry layout stored per queue slot.
package ifu_inst_queue_pkg;

    localparam int INST_DATA_WIDTH = 32;
    localparam int INST_ADDR_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [INST_DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [INST_DATA_WIDTH-1:0] inst;
        logic [INST_ADDR_WIDTH-1:0] addr;
        logic                       pred_branch;
    } inst_entry_t;

endpackage

// File: rtl/ifu_queue_mem.sv
// DEPTH-entry register array for queued instructions: one write port, one
// asynchronous read port. Contents are intentionally not reset.
module ifu_queue_mem
    import ifu_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  inst_entry_t   wdata,
    input  logic [AW-1:0] raddr,
    output inst_entry_t   rdata
);

    inst_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifu_inst_queue.sv
// Instruction queue between fetch and decode: buffers up to DEPTH entries and
// drives one registered instruction per cycle, with an empty-queue bypass path.
module ifu_inst_queue
    import ifu_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [INST_DATA_WIDTH-1:0]  inst_i,
    input  logic [INST_ADDR_WIDTH-1:0]  inst_addr_i,
    input  logic                        is_pred_branch_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    output logic [INST_DATA_WIDTH-1:0]  inst_o,
    output logic [INST_ADDR_WIDTH-1:0]  inst_addr_o,
    output logic                        is_pred_branch_o,
    output logic                        inst_valid_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          push, pop, bypass, mem_we, empty;
    inst_entry_t   wr_entry, rd_entry;

    assign empty      = (count == '0);
    assign in_ready_o = (count != CW'(DEPTH)) && !rst;
    assign push       = in_valid_i && in_ready_o && !flush_i;
    assign pop        = !stall_i && !empty;
    // Empty and draining: the incoming word goes straight to the output register.
    assign bypass     = push && !stall_i && empty;
    assign mem_we     = push && !bypass;

    assign wr_entry = '{inst: inst_i, addr: inst_addr_i, pred_branch: is_pred_branch_i};

    always_comb begin
        count_nxt = count;
        if (mem_we && !pop)      count_nxt = count + 1'b1;
        else if (!mem_we && pop) count_nxt = count - 1'b1;
    end

    ifu_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            inst_o           <= INST_NOP;
            inst_addr_o      <= '0;
            is_pred_branch_o <= 1'b0;
            inst_valid_o     <= 1'b0;
        end else begin
            if (mem_we) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            if (!stall_i) begin
                if (pop) begin
                    inst_o           <= rd_entry.inst;
                    inst_addr_o      <= rd_entry.addr;
                    is_pred_branch_o <= rd_entry.pred_branch;
                    inst_valid_o     <= 1'b1;
                end else if (bypass) begin
                    inst_o           <= inst_i;
                    inst_addr_o      <= inst_addr_i;
                    is_pred_branch_o <= is_pred_branch_i;
                    inst_valid_o     <= 1'b1;
                end else begin
                    inst_o           <= INST_NOP;
                    inst_addr_o      <= '0;
                    is_pred_branch_o <= 1'b0;
                    inst_valid_o     <= 1'b0;
                end
            end
        end
    end

    assign count_o = count;

endmodule
